// File: rtl/tart_clk_supervisor_if.sv
// Status and control bundle between the clock supervisor and the rest of the clock tree.
// "master" is the side that drives the lock flags and clear_fault; "slave" is the supervisor.
interface tart_clk_supervisor_if #(
    parameter int NUM_LOCKS  = 1,
    parameter int NUM_RESETS = 2
);
    logic [NUM_LOCKS-1:0]  locked_i;
    logic                  clear_fault;
    logic                  dcm_rst;
    logic [NUM_RESETS-1:0] rst_n_out;
    logic                  all_locked;
    logic                  fault;
    logic [2:0]            state;
    logic [7:0]            retry_cnt;
    logic [7:0]            loss_cnt;

    modport master (
        output locked_i, clear_fault,
        input  dcm_rst, rst_n_out, all_locked, fault, state, retry_cnt, loss_cnt
    );

    modport slave (
        input  locked_i, clear_fault,
        output dcm_rst, rst_n_out, all_locked, fault, state, retry_cnt, loss_cnt
    );
endinterface

// File: rtl/tart_clk_supervisor.sv
// Lock/reset supervisor for the TART clock tree: pulses the DCM reset, qualifies the lock
// flags, releases the domain resets in order and latches a fault after repeated timeouts.
//
// state     | meaning
// ----------+----------------------------------------------------------
// RESET_DCM | dcm_rst held high for RST_PULSE cycles
// WAIT_LOCK | waiting for STABLE_CYCLES of lock, bounded by LOCK_TIMEOUT
// SEQ       | releasing domain resets, SEQ_DELAY cycles apart
// RUN       | all domains out of reset, watching for lock loss
// FAULT     | retries exhausted, waiting for clear_fault
module tart_clk_supervisor #(
    parameter int NUM_LOCKS     = 1,
    parameter int NUM_RESETS    = 2,
    parameter int RST_PULSE     = 8,
    parameter int STABLE_CYCLES = 1024,
    parameter int LOCK_TIMEOUT  = 16384,
    parameter int SEQ_DELAY     = 16,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 16
) (
    input logic                  CLKIN,
    input logic                  reset_n,
    tart_clk_supervisor_if.slave sup
);

    typedef enum logic [2:0] {
        RESET_DCM = 3'd0,
        WAIT_LOCK = 3'd1,
        SEQ       = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } sup_state_t;

    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'((NUM_RESETS - 1) * SEQ_DELAY);
    localparam logic [7:0]       RETRY_MAX    = 8'(MAX_RETRIES);

    logic [NUM_LOCKS-1:0]  sync_q1;
    logic [NUM_LOCKS-1:0]  sync_q2;
    logic                  locked_s;

    sup_state_t            state_q, state_d;
    logic [CNT_W-1:0]      tmr_q, tmr_d;
    logic [CNT_W-1:0]      stable_q, stable_d;
    logic [7:0]            retry_q, retry_d;
    logic [7:0]            loss_q, loss_d;
    logic [NUM_RESETS-1:0] rst_q, rst_d;
    logic                  dcm_rst_q;
    logic                  fault_q;

    always_ff @(posedge CLKIN or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= sup.locked_i;
            sync_q2 <= sync_q1;
        end
    end

    // AND of the second synchroniser flops: all_locked follows the raw flags by two cycles
    assign locked_s = &sync_q2;

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        stable_d = '0;
        retry_d  = retry_q;
        loss_d   = loss_q;
        rst_d    = rst_q;

        case (state_q)
            RESET_DCM: begin
                rst_d = '0;
                if (tmr_q == PULSE_LAST) begin
                    state_d = WAIT_LOCK;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            WAIT_LOCK: begin
                rst_d    = '0;
                tmr_d    = tmr_q + 1'b1;
                stable_d = locked_s ? stable_q + 1'b1 : '0;
                if (locked_s && stable_q == STABLE_LAST) begin
                    state_d  = SEQ;
                    tmr_d    = '0;
                    stable_d = '0;
                end else if (tmr_q == TIMEOUT_LAST) begin
                    tmr_d    = '0;
                    stable_d = '0;
                    if (retry_q == RETRY_MAX) begin
                        state_d = FAULT;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = RESET_DCM;
                    end
                end
            end

            SEQ: begin
                tmr_d = tmr_q + 1'b1;
                for (int k = 0; k < NUM_RESETS; k++) begin
                    if (tmr_q == CNT_W'(k * SEQ_DELAY)) rst_d[k] = 1'b1;
                end
                if (tmr_q == RELEASE_LAST) begin
                    state_d = RUN;
                    tmr_d   = '0;
                    retry_d = '0;
                end
            end

            RUN: begin
                rst_d = '1;
                tmr_d = '0;
            end

            FAULT: begin
                rst_d = '0;
                tmr_d = '0;
                if (sup.clear_fault) begin
                    state_d = RESET_DCM;
                    retry_d = '0;
                end
            end

            default: begin
                state_d = RESET_DCM;
                tmr_d   = '0;
                rst_d   = '0;
            end
        endcase

        // Lock loss overrides any release or RUN transition decided above
        if ((state_q == SEQ || state_q == RUN) && !locked_s) begin
            state_d  = RESET_DCM;
            tmr_d    = '0;
            stable_d = '0;
            rst_d    = '0;
            retry_d  = '0;
            loss_d   = (loss_q == 8'hFF) ? loss_q : loss_q + 1'b1;
        end
    end

    always_ff @(posedge CLKIN or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RESET_DCM;
            tmr_q     <= '0;
            stable_q  <= '0;
            retry_q   <= '0;
            loss_q    <= '0;
            rst_q     <= '0;
            dcm_rst_q <= 1'b1;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            stable_q  <= stable_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            rst_q     <= rst_d;
            dcm_rst_q <= (state_d == RESET_DCM) || (state_d == FAULT);
            fault_q   <= (state_d == FAULT);
        end
    end

    assign sup.state      = state_q;
    assign sup.dcm_rst    = dcm_rst_q;
    assign sup.fault      = fault_q;
    assign sup.rst_n_out  = rst_q;
    assign sup.retry_cnt  = retry_q;
    assign sup.loss_cnt   = loss_q;
    assign sup.all_locked = locked_s;

endmodule

// File: tb/tb_tart_clk_supervisor.sv
// Scoreboard bench for tart_clk_supervisor: expectations are queued against cycle numbers
// as stimulus is scheduled and compared on the falling clock edge.
module tb_tart_clk_supervisor;

    localparam int NUM_LOCKS     = 2;
    localparam int NUM_RESETS    = 3;
    localparam int RST_PULSE     = 4;
    localparam int STABLE_CYCLES = 8;
    localparam int LOCK_TIMEOUT  = 64;
    localparam int SEQ_DELAY     = 4;
    localparam int MAX_RETRIES   = 2;
    localparam int CNT_W         = 16;

    localparam int S_DCM   = 0;
    localparam int S_RST   = 1;
    localparam int S_STATE = 2;
    localparam int S_RETRY = 3;
    localparam int S_LOSS  = 4;
    localparam int S_FAULT = 5;
    localparam int S_ALL   = 6;

    typedef struct {
        int    cyc;
        int    sel;
        int    val;
        string tag;
    } sb_item_t;

    logic     clk;
    logic     reset_n;
    int       cyc = 0;
    int       n_checks = 0;
    int       n_fail = 0;
    sb_item_t sb_q[$];
    sb_item_t mon_it;

    tart_clk_supervisor_if #(.NUM_LOCKS(NUM_LOCKS), .NUM_RESETS(NUM_RESETS)) sup_if ();

    tart_clk_supervisor #(
        .NUM_LOCKS    (NUM_LOCKS),
        .NUM_RESETS   (NUM_RESETS),
        .RST_PULSE    (RST_PULSE),
        .STABLE_CYCLES(STABLE_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .SEQ_DELAY    (SEQ_DELAY),
        .MAX_RETRIES  (MAX_RETRIES),
        .CNT_W        (CNT_W)
    ) dut (
        .CLKIN  (clk),
        .reset_n(reset_n),
        .sup    (sup_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int sample(input int sel);
        case (sel)
            S_DCM:   return int'(sup_if.dcm_rst);
            S_RST:   return int'(sup_if.rst_n_out);
            S_STATE: return int'(sup_if.state);
            S_RETRY: return int'(sup_if.retry_cnt);
            S_LOSS:  return int'(sup_if.loss_cnt);
            S_FAULT: return int'(sup_if.fault);
            default: return int'(sup_if.all_locked);
        endcase
    endfunction

    task automatic expect_at(input int c, input int sel, input int val, input string tag);
        sb_item_t it;
        int       i;
        it.cyc = c;
        it.sel = sel;
        it.val = val;
        it.tag = tag;
        i = sb_q.size();
        while (i > 0 && sb_q[i-1].cyc > c) i--;
        sb_q.insert(i, it);
    endtask

    // Release pattern for a SEQ entry at cycle s: bit k rises on cycle s+1+k*SEQ_DELAY
    task automatic push_release(input int s, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            expect_at(s + k * SEQ_DELAY, S_RST, (1 << k) - 1, "pre_release");
            expect_at(s + 1 + k * SEQ_DELAY, S_RST, (1 << (k + 1)) - 1, "release");
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            mon_it = sb_q.pop_front();
            check_val(mon_it.tag, sample(mon_it.sel), mon_it.val);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: cycle %0d reached without completion, expected finish", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    int p, d, e, c;

    initial begin
        reset_n = 1'b0;
        sup_if.locked_i = '0;
        sup_if.clear_fault = 1'b0;

        // Reset values
        wait_cyc(3);
        check_val("rst_state", sample(S_STATE), 0);
        check_val("rst_dcm", sample(S_DCM), 1);
        check_val("rst_rstn", sample(S_RST), 0);
        check_val("rst_fault", sample(S_FAULT), 0);
        check_val("rst_all_locked", sample(S_ALL), 0);
        check_val("rst_retry", sample(S_RETRY), 0);
        check_val("rst_loss", sample(S_LOSS), 0);

        // Clean bring-up: locks rise 10 cycles after reset release
        p = 4;
        expect_at(p, S_DCM, 1, "pulse0_first");
        expect_at(p + 3, S_DCM, 1, "pulse0_last");
        expect_at(p + 4, S_DCM, 0, "pulse0_off");
        expect_at(p + 4, S_STATE, 1, "wait_entry");
        expect_at(p + 11, S_ALL, 0, "sync_lat_1");
        expect_at(p + 12, S_ALL, 1, "sync_lat_2");
        expect_at(p + 19, S_STATE, 1, "wait_before_seq");
        expect_at(p + 20, S_STATE, 2, "seq_entry");
        push_release(p + 20, NUM_RESETS);
        expect_at(p + 29, S_STATE, 3, "run_entry");
        expect_at(p + 29, S_RETRY, 0, "run_retry");
        wait_cyc(p);
        reset_n = 1'b1;
        wait_cyc(p + 10);
        sup_if.locked_i = 2'b11;

        // Lock loss in RUN, one-cycle drop of lock[0]
        d = p + 40;
        expect_at(d + 2, S_RST, 7, "loss_pre_rst");
        expect_at(d + 2, S_STATE, 3, "loss_pre_state");
        expect_at(d + 2, S_ALL, 0, "loss_all_locked");
        expect_at(d + 3, S_RST, 0, "loss_rst");
        expect_at(d + 3, S_LOSS, 1, "loss_cnt_1");
        expect_at(d + 3, S_STATE, 0, "loss_state");
        expect_at(d + 3, S_DCM, 1, "loss_dcm");
        expect_at(d + 7, S_STATE, 1, "reacq_wait");
        push_release(d + 15, NUM_RESETS);
        expect_at(d + 24, S_STATE, 3, "reacq_run");
        wait_cyc(d);
        sup_if.locked_i[0] = 1'b0;
        wait_cyc(d + 1);
        sup_if.locked_i[0] = 1'b1;

        // Repeated losses until the counter saturates
        for (int i = 0; i < 300; i++) begin
            d = p + 70 + 30 * i;
            expect_at(d + 3, S_LOSS, (i + 2 > 255) ? 255 : i + 2, "loss_cnt");
            expect_at(d + 24, S_RST, 7, "reacq_rst");
            wait_cyc(d);
            sup_if.locked_i[0] = 1'b0;
            wait_cyc(d + 1);
            sup_if.locked_i[0] = 1'b1;
        end

        // Stability glitch on lock[1] after 5 stable cycles, then loss on the bit-2 release edge
        d = p + 70 + 30 * 300;
        expect_at(d + 3, S_LOSS, 255, "loss_sat");
        expect_at(d + 15, S_STATE, 1, "glitch_hold");
        expect_at(d + 20, S_STATE, 1, "glitch_wait");
        expect_at(d + 21, S_STATE, 2, "glitch_seq");
        expect_at(d + 21, S_FAULT, 0, "glitch_fault");
        push_release(d + 21, 2);
        expect_at(d + 29, S_RST, 3, "seqloss_pre_rst");
        expect_at(d + 29, S_STATE, 2, "seqloss_pre_state");
        expect_at(d + 30, S_RST, 0, "seqloss_rst");
        expect_at(d + 30, S_STATE, 0, "seqloss_state");
        expect_at(d + 30, S_LOSS, 255, "seqloss_loss");
        expect_at(d + 31, S_RST, 0, "seqloss_hold");
        wait_cyc(d);
        sup_if.locked_i[0] = 1'b0;
        wait_cyc(d + 1);
        sup_if.locked_i[0] = 1'b1;
        wait_cyc(d + 10);
        sup_if.locked_i[1] = 1'b0;
        wait_cyc(d + 11);
        sup_if.locked_i[1] = 1'b1;
        wait_cyc(d + 27);
        sup_if.locked_i[0] = 1'b0;

        // Timeouts with lock[0] held low, then FAULT and clear_fault
        e = d + 30;
        c = e + 210;
        for (int i = 0; i < 3; i++) begin
            expect_at(e + 68 * i, S_DCM, 1, "retry_pulse_first");
            expect_at(e + 68 * i + 1, S_RETRY, i, "retry_cnt");
            expect_at(e + 68 * i + 3, S_DCM, 1, "retry_pulse_last");
            expect_at(e + 68 * i + 4, S_DCM, 0, "retry_pulse_off");
            expect_at(e + 68 * i + 4, S_STATE, 1, "retry_wait");
            expect_at(e + 68 * i + 67, S_STATE, 1, "retry_wait_end");
        end
        expect_at(e + 102, S_STATE, 1, "clear_ignored_state");
        expect_at(e + 102, S_RETRY, 1, "clear_ignored_retry");
        expect_at(e + 204, S_STATE, 4, "fault_state");
        expect_at(e + 204, S_FAULT, 1, "fault_flag");
        expect_at(e + 204, S_DCM, 1, "fault_dcm");
        expect_at(e + 204, S_RETRY, 2, "fault_retry");
        expect_at(e + 204, S_RST, 0, "fault_rst");
        expect_at(c, S_STATE, 4, "fault_hold");
        expect_at(c + 1, S_STATE, 0, "clear_state");
        expect_at(c + 1, S_FAULT, 0, "clear_fault_flag");
        expect_at(c + 1, S_RETRY, 0, "clear_retry");
        expect_at(c + 1, S_DCM, 1, "clear_dcm");
        expect_at(c + 1, S_LOSS, 255, "clear_keeps_loss");
        expect_at(c + 4, S_DCM, 1, "clear_pulse_last");
        expect_at(c + 5, S_DCM, 0, "clear_pulse_off");
        expect_at(c + 5, S_STATE, 1, "clear_wait");
        wait_cyc(e + 100);
        sup_if.clear_fault = 1'b1;
        wait_cyc(e + 101);
        sup_if.clear_fault = 1'b0;
        wait_cyc(c);
        sup_if.clear_fault = 1'b1;
        wait_cyc(c + 1);
        sup_if.clear_fault = 1'b0;

        // Bring-up after clear, then asynchronous reset mid-cycle in RUN
        push_release(c + 13, NUM_RESETS);
        expect_at(c + 22, S_STATE, 3, "final_run");
        expect_at(c + 22, S_RETRY, 0, "final_retry");
        wait_cyc(c + 2);
        sup_if.locked_i = 2'b11;
        wait_cyc(c + 30);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("areset_rst", sample(S_RST), 0);
        check_val("areset_dcm", sample(S_DCM), 1);
        check_val("areset_state", sample(S_STATE), 0);
        check_val("areset_retry", sample(S_RETRY), 0);
        check_val("areset_loss", sample(S_LOSS), 0);
        check_val("areset_all_locked", sample(S_ALL), 0);
        check_val("areset_fault", sample(S_FAULT), 0);
        check_val("sb_drain", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
